// File: rtl/perm_input_loader.sv
// Lane-serial loader: assembles LANES x LANE_W state, fires perm_start once the engine is ready,
// then holds state_out through the engine's capture cycle. Optional in_last/err checker: PERM_LOADER_LAST_CHK_EN.
module perm_input_loader #(
    parameter int LANE_W = 64,
    parameter int LANES  = 25,
    parameter int CNT_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [LANE_W-1:0]       in_data,
`ifdef PERM_LOADER_LAST_CHK_EN
    input  logic                    in_last,
    output logic                    err,
`endif
    output logic                    in_ready,
    input  logic                    flush,
    input  logic                    perm_ready,
    output logic                    perm_start,
    output logic [LANES*LANE_W-1:0] state_out,
    output logic [CNT_W-1:0]        lane_cnt,
    output logic                    busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_WAIT = 3'd2,
        ST_FIRE = 3'd3,
        ST_HOLD = 3'd4
    } fsm_t;

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    fsm_t                    fsm_q, fsm_d;
    logic [CNT_W-1:0]        lane_cnt_q, lane_cnt_d;
    logic [LANES*LANE_W-1:0] state_out_q, state_out_d;
`ifdef PERM_LOADER_LAST_CHK_EN
    logic                    err_q, err_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            lane_cnt_q  <= '0;
            state_out_q <= '0;
`ifdef PERM_LOADER_LAST_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            lane_cnt_q  <= lane_cnt_d;
            state_out_q <= state_out_d;
`ifdef PERM_LOADER_LAST_CHK_EN
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        lane_cnt_d  = lane_cnt_q;
        state_out_d = state_out_q;
`ifdef PERM_LOADER_LAST_CHK_EN
        err_d       = err_q;
`endif
        case (fsm_q)
            ST_IDLE, ST_FILL: begin
                // flush outranks a beat presented in the same cycle
                if (flush) begin
                    lane_cnt_d = '0;
                    fsm_d      = ST_IDLE;
                end else if (in_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (lane_cnt_q == CNT_W'(i)) begin
                            state_out_d[i*LANE_W +: LANE_W] = in_data;
                        end
                    end
`ifdef PERM_LOADER_LAST_CHK_EN
                    if (in_last != (lane_cnt_q == LAST_LANE)) begin
                        err_d = 1'b1;
                    end
`endif
                    if (lane_cnt_q == LAST_LANE) begin
                        lane_cnt_d = '0;
                        fsm_d      = ST_WAIT;
                    end else begin
                        lane_cnt_d = lane_cnt_q + CNT_W'(1);
                        fsm_d      = ST_FILL;
                    end
                end
            end
            ST_WAIT: begin
                if (perm_ready) begin
                    fsm_d = ST_FIRE;
                end
            end
            ST_FIRE: fsm_d = ST_HOLD;
            ST_HOLD: fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
        endcase
`ifdef PERM_LOADER_LAST_CHK_EN
        if (flush) begin
            err_d = 1'b0;
        end
`endif
    end

    assign in_ready   = (fsm_q == ST_IDLE) || (fsm_q == ST_FILL);
    assign busy       = (fsm_q == ST_WAIT) || (fsm_q == ST_FIRE) || (fsm_q == ST_HOLD);
    assign perm_start = (fsm_q == ST_FIRE);
    assign state_out  = state_out_q;
    assign lane_cnt   = lane_cnt_q;
`ifdef PERM_LOADER_LAST_CHK_EN
    assign err        = err_q;
`endif

endmodule

// File: tb/tb_perm_input_loader.sv
// Directed bench for perm_input_loader: frame assembly, start timing, flush, async reset, bubbles.
module tb_perm_input_loader;

    localparam int LANE_W = 64;
    localparam int LANES  = 25;
    localparam int CNT_W  = 5;
    localparam int SW     = LANES * LANE_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [LANE_W-1:0] in_data;
    logic              in_ready;
    logic              flush;
    logic              perm_ready;
    logic              perm_start;
    logic [SW-1:0]     state_out;
    logic [CNT_W-1:0]  lane_cnt;
    logic              busy;
`ifdef PERM_LOADER_LAST_CHK_EN
    logic              in_last;
    logic              err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    perm_input_loader #(.LANE_W(LANE_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
`ifdef PERM_LOADER_LAST_CHK_EN
        .in_last    (in_last),
        .err        (err),
`endif
        .in_ready   (in_ready),
        .flush      (flush),
        .perm_ready (perm_ready),
        .perm_start (perm_start),
        .state_out  (state_out),
        .lane_cnt   (lane_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] mk_frame(input logic [LANE_W-1:0] base);
        logic [SW-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = base + LANE_W'(i);
        return v;
    endfunction

    // Presents beats lo..hi-1 back to back; entered and left just after a rising edge.
    task automatic stream(input logic [LANE_W-1:0] base, input int lo, input int hi, input int bad);
        for (int i = lo; i < hi; i++) begin
            in_valid = 1'b1;
            in_data  = base + LANE_W'(i);
`ifdef PERM_LOADER_LAST_CHK_EN
            in_last  = (i == LANES - 1) ^ (i == bad);
`endif
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
`ifdef PERM_LOADER_LAST_CHK_EN
        in_last  = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (perm_start !== 1'b0) begin n_bad++; $display("FAIL rst_perm_start: got %b want 0", perm_start); end
        n_cmp++; if (lane_cnt !== '0) begin n_bad++; $display("FAIL rst_lane_cnt: got %0d want 0", lane_cnt); end
        n_cmp++; if (state_out !== '0) begin n_bad++; $display("FAIL rst_state_out: nonzero, want 0"); end
`ifdef PERM_LOADER_LAST_CHK_EN
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
`endif
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_frame();
        perm_ready = 1'b1;
        stream(64'h1000, 0, LANES, -1);
        @(negedge clk); // t+1: WAIT
        n_cmp++; if (perm_start !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL t1_wait: ps=%b busy=%b rdy=%b want 0 1 0", perm_start, busy, in_ready); end
        n_cmp++; if (state_out !== mk_frame(64'h1000)) begin n_bad++; $display("FAIL t1_state: lane0=%h want 1000", state_out[63:0]); end
        n_cmp++; if (lane_cnt !== 5'd0) begin n_bad++; $display("FAIL t1_lane_cnt: got %0d want 0", lane_cnt); end
        @(negedge clk); // t+2: FIRE
        n_cmp++; if (perm_start !== 1'b1) begin n_bad++; $display("FAIL t1_fire: got %b want 1", perm_start); end
        @(negedge clk); // t+3: HOLD
        n_cmp++; if (perm_start !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL t1_hold: ps=%b rdy=%b busy=%b want 0 0 1", perm_start, in_ready, busy); end
        @(negedge clk); // t+4: IDLE
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL t1_reopen: rdy=%b busy=%b want 1 0", in_ready, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_wait_ready();
        perm_ready = 1'b0;
        stream(64'h2000, 0, LANES, -1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1 || perm_start !== 1'b0) begin
                n_bad++; $display("FAIL t2_wait%0d: rdy=%b busy=%b ps=%b want 0 1 0", k, in_ready, busy, perm_start); end
        end
        #1 perm_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (perm_start !== 1'b1) begin n_bad++; $display("FAIL t2_fire: got %b want 1", perm_start); end
        n_cmp++; if (state_out !== mk_frame(64'h2000)) begin n_bad++; $display("FAIL t2_state: lane24=%h want 2018", state_out[24*64 +: 64]); end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [SW-1:0] exp_st;
        int            starts;
        stream(64'h3000, 0, 7, -1);
        in_valid = 1'b1; in_data = 64'hDEAD_BEEF; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        exp_st = mk_frame(64'h2000);
        for (int i = 0; i < 7; i++) exp_st[i*LANE_W +: LANE_W] = 64'h3000 + 64'(i);
        @(negedge clk);
        n_cmp++; if (lane_cnt !== 5'd0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL t3_flush: cnt=%0d rdy=%b want 0 1", lane_cnt, in_ready); end
        n_cmp++; if (state_out !== exp_st) begin n_bad++; $display("FAIL t3_drop: lane7=%h want 2007", state_out[7*64 +: 64]); end
        @(posedge clk); #1;
        stream(64'h4000, 0, LANES, -1);
        starts = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (perm_start === 1'b1) starts++;
        end
        n_cmp++; if (starts != 1) begin n_bad++; $display("FAIL t3_starts: got %0d want 1", starts); end
        n_cmp++; if (state_out !== mk_frame(64'h4000)) begin n_bad++; $display("FAIL t3_state: lane0=%h want 4000", state_out[63:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int starts;
        stream(64'h6000, 0, 12, -1);
        @(negedge clk);
        n_cmp++; if (lane_cnt !== 5'd12) begin n_bad++; $display("FAIL t4_cnt12: got %0d want 12", lane_cnt); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (lane_cnt !== '0 || state_out !== '0 || busy !== 1'b0 || in_ready !== 1'b1 || perm_start !== 1'b0) begin
            n_bad++; $display("FAIL t4_rst_fill: cnt=%0d busy=%b rdy=%b ps=%b want 0 0 1 0", lane_cnt, busy, in_ready, perm_start); end
        rst = 1'b0;
        @(posedge clk); #1;
        stream(64'h7000, 0, LANES, -1);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (perm_start !== 1'b1) begin n_bad++; $display("FAIL t4_fire: got %b want 1", perm_start); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (perm_start !== 1'b0 || busy !== 1'b0 || state_out !== '0 || lane_cnt !== '0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL t4_rst_fire: ps=%b busy=%b cnt=%0d rdy=%b want 0 0 0 1", perm_start, busy, lane_cnt, in_ready); end
        rst = 1'b0;
        starts = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (perm_start === 1'b1) starts++;
        end
        n_cmp++; if (starts != 0) begin n_bad++; $display("FAIL t4_no_start: got %0d want 0", starts); end
        @(posedge clk); #1;
    endtask

    task automatic test_bubbles();
        int sent;
        int starts;
        sent   = 0;
        starts = 0;
        perm_ready = 1'b1;
        for (int cyc = 0; cyc < 2000 && starts < 3; cyc++) begin
            @(posedge clk); #1;
            in_valid = (sent < 3 * LANES) && ($urandom_range(0, 1) == 1);
            in_data  = in_valid ? 64'h5000 + 64'((sent / LANES) * 256 + (sent % LANES))
                                : {$urandom, $urandom};
`ifdef PERM_LOADER_LAST_CHK_EN
            in_last  = in_valid && ((sent % LANES) == LANES - 1);
`endif
            @(negedge clk);
            if (perm_start === 1'b1) begin
                n_cmp++; if (state_out !== mk_frame(64'h5000 + 64'(starts * 256))) begin
                    n_bad++; $display("FAIL t5_frame%0d: lane0=%h want %h", starts, state_out[63:0], 64'h5000 + 64'(starts * 256)); end
                starts++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
`ifdef PERM_LOADER_LAST_CHK_EN
        in_last  = 1'b0;
`endif
        n_cmp++; if (starts != 3 || sent != 3 * LANES) begin
            n_bad++; $display("FAIL t5_count: starts=%0d beats=%0d want 3 75", starts, sent); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

`ifdef PERM_LOADER_LAST_CHK_EN
    task automatic test_last_chk();
        perm_ready = 1'b1;
        stream(64'h8000, 0, 20, 20);
        @(negedge clk);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t6_err_pre: got %b want 0", err); end
        @(posedge clk); #1;
        stream(64'h8000, 20, 21, 20);
        @(negedge clk);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t6_err_set: got %b want 1", err); end
        @(posedge clk); #1;
        stream(64'h8000, 21, LANES, 20);
        @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
        n_cmp++; if (err !== 1'b1 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL t6_err_sticky: err=%b rdy=%b want 1 1", err, in_ready); end
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t6_err_flush: got %b want 0", err); end
        @(posedge clk); #1;
        stream(64'h9000, 0, LANES, -1);
        @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
        n_cmp++; if (err !== 1'b0 || state_out !== mk_frame(64'h9000)) begin
            n_bad++; $display("FAIL t6_good_frame: err=%b lane0=%h want 0 9000", err, state_out[63:0]); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        flush      = 1'b0;
        perm_ready = 1'b0;
`ifdef PERM_LOADER_LAST_CHK_EN
        in_last    = 1'b0;
`endif
        test_reset();
        test_frame();
        test_wait_ready();
        test_flush();
        test_async_reset();
        test_bubbles();
`ifdef PERM_LOADER_LAST_CHK_EN
        test_last_chk();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
